// File: rtl/lwc_seg_pkg.sv
// Shared state encoding and constant helpers for the LWC segment source.
package lwc_seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } seg_state_e;

  // Ceiling log2 usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lwc_byte_window.sv
// Combinational NB-byte read window over the byte buffer with zero padding,
// byte-keep mask and last-word detection.
module lwc_byte_window
  import lwc_seg_pkg::*;
#(
  parameter int unsigned BUSW  = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNTW  = clog2(DEPTH) + 1
) (
  input  logic [7:0]        mem [DEPTH],
  input  logic [CNTW:0]     rd_ptr,
  input  logic [CNTW-1:0]   len,
  output logic [BUSW-1:0]   data,
  output logic [BUSW/8-1:0] keep,
  output logic              last
);

  localparam int unsigned NB = BUSW / 8;
  localparam int unsigned AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  logic [CNTW:0] len_x;

  // Compares run one bit wider than the counters so a full buffer never wraps.
  assign len_x = (CNTW+1)'(len);

  always_comb begin
    data = '0;
    keep = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if ((rd_ptr + (CNTW+1)'(k)) < len_x) begin
        keep[NB-1-k]           = 1'b1;
        data[(NB-1-k)*8 +: 8]  = mem[AW'(rd_ptr + (CNTW+1)'(k))];
      end
    end
  end

  assign last = (rd_ptr + (CNTW+1)'(NB)) >= len_x;

endmodule

// File: rtl/lwc_seg_source.sv
// Byte-loaded buffer that streams its contents as BUSW-wide valid/ready words,
// with exact length tracking, zero-padded final word and replay.
module lwc_seg_source
  import lwc_seg_pkg::*;
#(
  parameter int unsigned BUSW  = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNTW  = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              wr_full,
  output logic [CNTW-1:0]   level,
  input  logic              start,
  input  logic              rewind,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic [BUSW-1:0]   o_data,
  output logic [BUSW/8-1:0] o_keep,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last
);

  localparam int unsigned NB = BUSW / 8;
  localparam int unsigned AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  seg_state_e        state_q, state_d;
  logic [CNTW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]   len_q, len_d;
  logic [CNTW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem [DEPTH];
  logic              wr_accept;
  logic [BUSW-1:0]   win_data;
  logic [NB-1:0]     win_keep;
  logic              win_last;

  assign wr_full   = (wr_ptr_q == CNTW'(DEPTH));
  assign level     = wr_ptr_q;
  assign wr_accept = (state_q == S_IDLE) && wr_en && !wr_full;

  // Buffer storage; contents survive reset and are overwritten on reload.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[AW'(wr_ptr_q)] <= wr_data;
    end
  end

  lwc_byte_window #(
    .BUSW  (BUSW),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_window (
    .mem    (mem),
    .rd_ptr (rd_ptr_q),
    .len    (len_q),
    .data   (win_data),
    .keep   (win_keep),
    .last   (win_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          wr_ptr_d = wr_ptr_q + CNTW'(1);
        end
        if (start) begin
          // A byte written on the start edge belongs to this segment.
          len_d    = wr_accept ? (wr_ptr_q + CNTW'(1)) : wr_ptr_q;
          rd_ptr_d = '0;
          state_d  = (len_d != '0) ? S_STREAM : S_DONE;
        end else if (clear) begin
          wr_ptr_d = '0;
        end
      end
      S_STREAM: begin
        if (o_ready) begin
          if (win_last) begin
            state_d = S_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + (CNTW+1)'(NB);
          end
        end
      end
      S_DONE: begin
        if (rewind) begin
          rd_ptr_d = '0;
          if (len_q != '0) begin
            state_d = S_STREAM;
          end
        end else if (clear || start) begin
          wr_ptr_d = '0;
          len_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_STREAM);
  assign done    = (state_q == S_DONE);
  assign o_valid = busy;
  assign o_data  = busy ? win_data : '0;
  assign o_keep  = busy ? win_keep : '0;
  assign o_last  = busy && win_last;

endmodule

// File: tb/tb_lwc_seg_source.sv
// Directed bench for lwc_seg_source: a byte model builds expected words into a
// scoreboard queue at start, and a negedge monitor checks every transfer.
module tb_lwc_seg_source;
  import lwc_seg_pkg::*;

  localparam int unsigned BUSW  = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNTW  = 7;
  localparam int unsigned NB    = BUSW / 8;

  typedef struct packed {
    logic [BUSW-1:0] d;
    logic [NB-1:0]   k;
    logic            l;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            wr_full;
  logic [CNTW-1:0] level;
  logic            start;
  logic            rewind;
  logic            clear;
  logic            busy;
  logic            done;
  logic [BUSW-1:0] o_data;
  logic [NB-1:0]   o_keep;
  logic            o_valid;
  logic            o_ready;
  logic            o_last;

  int              errors = 0;
  int              checks = 0;
  int              xfers  = 0;
  logic [7:0]      model [$];
  word_t           exp_q [$];
  word_t           got_q [$];
  word_t           prev_got [$];
  logic            chk_done_next = 1'b0;
  logic            prev_stall    = 1'b0;
  word_t           prev_word;
  word_t           e_w;
  logic            same;

  lwc_seg_source #(
    .BUSW  (BUSW),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .wr_full (wr_full),
    .level   (level),
    .start   (start),
    .rewind  (rewind),
    .clear   (clear),
    .busy    (busy),
    .done    (done),
    .o_data  (o_data),
    .o_keep  (o_keep),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected words derived from the byte model: big-endian packing, zero pad.
  task automatic push_expected();
    int    n;
    int    nw;
    word_t w;
    n  = model.size();
    nw = (n + NB - 1) / NB;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int k = 0; k < NB; k++) begin
        if (wi * NB + k < n) begin
          w.d[(NB-1-k)*8 +: 8] = model[wi*NB + k];
          w.k[NB-1-k]          = 1'b1;
        end
      end
      w.l = (wi == nw - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    if (model.size() < DEPTH) model.push_back(b);
  endtask

  task automatic go();
    push_expected();
    xfers = 0;
    got_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk(tag, 64'(done), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clr();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model.delete();
  endtask

  // Transfer monitor: scoreboard pop, stall stability and done-after-last.
  always @(negedge clk) begin
    if (chk_done_next) chk("done_after_last", 64'(done), 64'd1);
    if (prev_stall && o_valid) chk("stall_hold", 64'({o_data, o_keep, o_last}), 64'(prev_word));
    chk_done_next = 1'b0;
    if (o_valid && o_ready) begin
      xfers++;
      got_q.push_back({o_data, o_keep, o_last});
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e_w = exp_q.pop_front();
        chk("sb_data", 64'(o_data), 64'(e_w.d));
        chk("sb_keep", 64'(o_keep), 64'(e_w.k));
        chk("sb_last", 64'(o_last), 64'(e_w.l));
      end
      chk_done_next = o_last;
    end
    prev_stall = o_valid && !o_ready;
    prev_word  = {o_data, o_keep, o_last};
  end

  initial begin
    logic [7:0] hdr [8];
    logic [4:0] bp_ready;
    hdr = '{8'h40, 8'h00, 8'h00, 8'h00, 8'hC2, 8'h00, 8'h00, 8'h10};
    bp_ready = 5'b00101;
    rst = 1'b0; wr_data = '0; wr_en = 1'b0; start = 1'b0;
    rewind = 1'b0; clear = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_done",  64'(done),    64'd0);
    chk("rst_full",  64'(wr_full), 64'd0);
    chk("rst_level", 64'(level),   64'd0);
    chk("rst_out",   64'({o_data, o_keep, o_last}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Key-segment header plus 16 payload bytes.
    for (int i = 0; i < 8; i++) wr(hdr[i]);
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("t1_level", 64'(level), 64'd24);
    go();
    wait_done("t1_done", 40);
    chk("t1_words", 64'(xfers), 64'd6);
    if (got_q.size() == 6) begin
      chk("t1_w0", 64'(got_q[0].d), 64'h40000000);
      chk("t1_w2", 64'(got_q[2].d), 64'h00010203);
      chk("t1_w5", 64'(got_q[5]), 64'({32'h0C0D0E0F, 4'hF, 1'b1}));
    end

    // Replay must reproduce the identical word sequence.
    prev_got = got_q;
    rewind = 1'b1;
    push_expected();
    xfers = 0;
    got_q.delete();
    @(posedge clk); #1;
    rewind = 1'b0;
    wait_done("rw_done", 40);
    same = (got_q.size() == prev_got.size());
    for (int i = 0; i < got_q.size() && i < prev_got.size(); i++)
      if (got_q[i] !== prev_got[i]) same = 1'b0;
    chk("rw_identical", 64'(same), 64'd1);

    clr();
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_done",  64'(done),  64'd0);

    // Five bytes: one full word then a one-byte padded word.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    go();
    wait_done("t2_done", 20);
    chk("t2_words", 64'(xfers), 64'd2);
    if (got_q.size() == 2) begin
      chk("t2_w0", 64'(got_q[0]), 64'({32'h01020304, 4'hF, 1'b0}));
      chk("t2_w1", 64'(got_q[1]), 64'({32'h05000000, 4'h8, 1'b1}));
    end
    clr();

    // Backpressure on an 8-byte segment.
    for (int i = 0; i < 8; i++) wr(8'hA0 + 8'(i));
    o_ready = 1'b0;
    go();
    for (int i = 4; i >= 0; i--) begin
      o_ready = bp_ready[i];
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    chk("bp_xfers", 64'(xfers), 64'd2);
    wait_done("bp_done", 5);
    clr();

    // Empty segment goes straight to DONE.
    chk("z_level", 64'(level), 64'd0);
    go();
    chk("z_valid", 64'(o_valid), 64'd0);
    chk("z_done",  64'(done),    64'd1);
    chk("z_xfers", 64'(xfers),   64'd0);
    clr();

    // Fill to capacity, then one dropped write.
    for (int i = 0; i < DEPTH; i++) wr(8'(i) ^ 8'h5A);
    chk("f_full",  64'(wr_full), 64'd1);
    chk("f_level", 64'(level),   64'(DEPTH));
    wr(8'hEE);
    chk("f_level_drop", 64'(level), 64'(DEPTH));
    go();
    wait_done("f_done", 40);
    chk("f_words", 64'(xfers), 64'(DEPTH / NB));
    if (got_q.size() == DEPTH / NB) begin
      chk("f_lastbyte", 64'(got_q[DEPTH/NB-1].d[7:0]), 64'(8'(DEPTH - 1) ^ 8'h5A));
      chk("f_lastflag", 64'(got_q[DEPTH/NB-1].l), 64'd1);
    end
    clr();

    // Reset in the middle of a stalled stream.
    for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i));
    o_ready = 1'b0;
    go();
    @(posedge clk); #1;
    chk("mr_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr_valid", 64'(o_valid), 64'd0);
    chk("mr_level", 64'(level),   64'd0);
    chk("mr_busy0", 64'(busy),    64'd0);
    chk("mr_done0", 64'(done),    64'd0);
    rst = 1'b1;
    exp_q.delete();
    model.delete();
    o_ready = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset: a fresh three-byte segment.
    for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i));
    go();
    wait_done("rc_done", 10);
    chk("rc_words", 64'(xfers), 64'd1);
    if (got_q.size() == 1)
      chk("rc_w0", 64'(got_q[0]), 64'({32'hC0C1C200, 4'hE, 1'b1}));

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lwc_seg_source.md
Name: lwc_seg_source

Overview:
- Parametrised, synthesizable byte-stream source that feeds one LWC public or secret data port (pdi_* or sdi_*) with BUSW-wide words over valid/ready.
- Generalises the hand-built shift FIFOs used on the LWC benches: configurable bus width and depth, exact byte-length tracking, zero-padded final word with byte-keep mask, last flag, and replay.
- Instantiated once per LWC input channel, on benches and in on-board test harnesses.

Parameters:
- BUSW, 32, output word width in bits; multiple of 8, one of 8/16/32/64.
- DEPTH, 1024, buffer capacity in bytes; power of two, at least BUSW/8.
- CNTW, clog2(DEPTH)+1, width of the byte counters and pointers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active low
- wr_data  in  8  byte to append to the buffer
- wr_en  in  1  append strobe; honoured only in IDLE and when not full
- wr_full  out  1  buffer holds DEPTH bytes
- level  out  CNTW  number of bytes loaded (wr_ptr)
- start  in  1  begin streaming the loaded bytes
- rewind  in  1  in DONE: replay the same contents from byte 0
- clear  in  1  in IDLE or DONE: empty the buffer
- busy  out  1  state is STREAM
- done  out  1  state is DONE
- o_data  out  BUSW  output word; lowest-address byte in bits [BUSW-1:BUSW-8]
- o_keep  out  BUSW/8  valid-byte mask; MSB corresponds to the MSB byte
- o_valid  out  1  o_data is valid
- o_ready  in  1  downstream accepts the word
- o_last  out  1  current word holds the final byte

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; wr_ptr=0, rd_ptr=0, len=0.
  - All outputs 0, except wr_full=0 and level=0.
  - Buffer contents are not cleared and are don't-care.
  - Reset overrides every other input on that edge, including mid-stream.
- Constant: NB = BUSW/8.
- State IDLE:
  - wr_en && !wr_full: mem[wr_ptr] <= wr_data; wr_ptr += 1.
  - wr_full is combinational: wr_full = (wr_ptr == DEPTH). Writes while full are dropped silently.
  - start: len <= wr_ptr plus 1 if a write is accepted on the same edge; rd_ptr <= 0.
    - Next state is STREAM if that length is nonzero, otherwise DONE.
  - clear (start low): wr_ptr <= 0.
  - start and clear together: start wins.
- State STREAM:
  - o_valid = 1.
  - o_data byte k (k = 0..NB-1, k=0 is the MSB byte) = mem[rd_ptr+k] when rd_ptr+k < len, else 8'h00.
  - o_keep bit (NB-1-k) = (rd_ptr+k < len).
  - o_last = (rd_ptr + NB >= len).
  - o_data, o_keep and o_last are combinational from rd_ptr and held stable while o_valid && !o_ready.
  - Transfer = o_valid && o_ready.
    - Not last: rd_ptr += NB.
    - Last: state <= DONE.
  - Throughput is one word per cycle when o_ready is held high. First o_valid appears in the cycle after start.
  - wr_en, start and clear are ignored in STREAM.
- State DONE:
  - done = 1, o_valid = 0.
  - rewind: rd_ptr <= 0; state <= STREAM if len != 0.
  - clear: wr_ptr <= 0, len <= 0; state <= IDLE.
  - rewind and clear together: rewind wins.
  - start in DONE: treated as clear followed by IDLE, i.e. state <= IDLE and wr_ptr <= 0.
- Arithmetic:
  - rd_ptr and the rd_ptr+k comparisons are computed at CNTW+1 bits, so the last-word compare does not wrap at DEPTH.
  - Word count = ceil(len/NB).
- Exact length: a bench writing N bytes gets exactly ceil(N/NB) words. The previous bench FIFOs emitted an extra word; this block must not.

Decomposition:
- Package lwc_seg_pkg:
  - state encoding localparams S_IDLE=2'd0, S_STREAM=2'd1, S_DONE=2'd2;
  - clog2 constant function.
- One sub-module, lwc_byte_window:
  - combinational;
  - from mem, rd_ptr and len, produces the NB-byte window, the zero padding, o_keep and o_last.
- The top module holds the memory, the pointers and the FSM.

Test Plan:
- Load key-segment header bytes 40,00,00,00,C2,00,00,10, then bytes 00..0F, then start with o_ready=1 (BUSW=32):
  - exactly 6 words;
  - word0 = 40000000, word2 = 00010203;
  - word5 = 0C0D0E0F with o_last=1 and o_keep=F;
  - done=1 on the next cycle.
- Load 5 bytes 01..05, start (BUSW=32):
  - word0 = 01020304 with o_keep=F, o_last=0;
  - word1 = 05000000 with o_keep=8, o_last=1.
- Backpressure: 8 bytes loaded; o_ready toggles 0,0,1,0,1:
  - o_data is stable while stalled;
  - exactly 2 transfers occur;
  - no byte is skipped or duplicated.
- start with 0 bytes loaded:
  - o_valid never asserts;
  - done=1 one cycle later.
- Fill DEPTH bytes then one extra write:
  - wr_full=1 and level=DEPTH;
  - the extra byte is dropped;
  - the stream ends on byte DEPTH-1 with o_last=1.
- Multi-phase:
  - rewind in DONE replays an identical word sequence;
  - pulling rst low mid-STREAM returns to IDLE with o_valid=0 and level=0 on the next edge;
  - clear in DONE returns to IDLE with level=0.
